// File: rtl/pipe_stage_chain_pkg.sv
// ---------------------------------------------------------------------------
// pipe_stage_chain_pkg : stall-bus constants and chain operation type
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package pipe_stage_chain_pkg;

  localparam logic Stop   = 1'b1;
  localparam logic NoStop = 1'b0;

  localparam int STALL_BUS_W = 6;
  typedef logic [STALL_BUS_W-1:0] StallBus;

  localparam int EX_TO_DC_WD  = 152;
  localparam int DC_TO_MEM_WD = 128;

  localparam int PIPE_CHAIN_MAX_DEPTH = 4;

  typedef enum logic [1:0] {
    OP_FLUSH  = 2'd0,
    OP_SHIFT  = 2'd1,
    OP_BUBBLE = 2'd2,
    OP_HOLD   = 2'd3
  } chain_op_e;

endpackage

`default_nettype wire

// File: rtl/pipe_stage_entry.sv
// ---------------------------------------------------------------------------
// pipe_stage_entry : one payload+valid flop of the stage chain
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module pipe_stage_entry #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear_i,
  input  logic             load_i,
  input  logic             bubble_i,
  input  logic [WIDTH-1:0] d_bus_i,
  input  logic             d_valid_i,
  output logic [WIDTH-1:0] bus_o,
  output logic             valid_o,
  output logic             valid_d_o
);

  logic [WIDTH-1:0] bus_d, bus_q;
  logic             valid_d, valid_q;

  // Invalid entries always hold a zero payload so write-enables need no gating.
  always_comb begin
    bus_d   = bus_q;
    valid_d = valid_q;
    if (clear_i || bubble_i) begin
      bus_d   = '0;
      valid_d = 1'b0;
    end else if (load_i) begin
      valid_d = d_valid_i;
      bus_d   = d_valid_i ? d_bus_i : '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bus_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      bus_q   <= bus_d;
      valid_q <= valid_d;
    end
  end

  assign bus_o     = bus_q;
  assign valid_o   = valid_q;
  assign valid_d_o = valid_d;

endmodule

`default_nettype wire

// File: rtl/pipe_stage_chain.sv
// ---------------------------------------------------------------------------
// pipe_stage_chain : DEPTH-entry stall-aware pipeline latch chain
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module pipe_stage_chain
  import pipe_stage_chain_pkg::*;
#(
  parameter  int WIDTH   = EX_TO_DC_WD,
  parameter  int DEPTH   = 2,
  parameter  int STALL_W = STALL_BUS_W,
  parameter  int IN_IDX  = 4,
  parameter  int OUT_IDX = 5,
  parameter  int CNT_W   = 32,
  localparam int OCC_W   = $clog2(DEPTH + 1)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [STALL_W-1:0]     stall,
  input  logic                   flush,
  input  logic [WIDTH-1:0]       in_bus,
  input  logic                   in_valid,
  output logic [WIDTH-1:0]       out_bus,
  output logic                   out_valid,
  output logic [WIDTH*DEPTH-1:0] entry_bus,
  output logic [DEPTH-1:0]       entry_valid,
  output logic [OCC_W-1:0]       occupancy,
  output logic [CNT_W-1:0]       stall_cycles
);

  chain_op_e        op;
  logic             in_stop, out_stop, hold_cond;
  logic [WIDTH-1:0] ent_bus [DEPTH];
  logic [DEPTH-1:0] ent_valid_d;
  logic [OCC_W-1:0] occ_d, occ_q;
  logic [CNT_W-1:0] cnt_d, cnt_q;
  logic             unused_stall;

  assign in_stop      = stall[IN_IDX];
  assign out_stop     = stall[OUT_IDX];
  assign unused_stall = ^stall;
  assign hold_cond    = (in_stop == Stop) && (out_stop == Stop);

  // The illegal NoStop-in/Stop-out combination falls through to SHIFT.
  always_comb begin
    op = OP_HOLD;
    if (flush) begin
      op = OP_FLUSH;
    end else if (in_stop == NoStop) begin
      op = OP_SHIFT;
    end else if (out_stop == NoStop) begin
      op = OP_BUBBLE;
    end
  end

  for (genvar k = 0; k < DEPTH; k++) begin : g_entry
    logic [WIDTH-1:0] d_bus;
    logic             d_valid;
    logic             load;
    logic             bubble;

    if (k == 0) begin : g_head
      assign d_bus   = in_bus;
      assign d_valid = in_valid;
      assign load    = (op == OP_SHIFT);
      assign bubble  = (op == OP_BUBBLE);
    end else begin : g_tail
      assign d_bus   = ent_bus[k-1];
      assign d_valid = entry_valid[k-1];
      assign load    = (op == OP_SHIFT) || (op == OP_BUBBLE);
      assign bubble  = 1'b0;
    end

    pipe_stage_entry #(
      .WIDTH(WIDTH)
    ) u_entry (
      .clk       (clk),
      .rst       (rst),
      .clear_i   (op == OP_FLUSH),
      .load_i    (load),
      .bubble_i  (bubble),
      .d_bus_i   (d_bus),
      .d_valid_i (d_valid),
      .bus_o     (ent_bus[k]),
      .valid_o   (entry_valid[k]),
      .valid_d_o (ent_valid_d[k])
    );

    assign entry_bus[k*WIDTH +: WIDTH] = ent_bus[k];
  end

  // Popcount of next-state valids keeps occupancy aligned with the entries.
  always_comb begin
    occ_d = '0;
    for (int i = 0; i < DEPTH; i++) begin
      occ_d = occ_d + OCC_W'(ent_valid_d[i]);
    end
  end

  assign cnt_d = hold_cond ? cnt_q + CNT_W'(1) : cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      occ_q <= '0;
      cnt_q <= '0;
    end else begin
      occ_q <= occ_d;
      cnt_q <= cnt_d;
    end
  end

  assign out_bus      = ent_bus[DEPTH-1];
  assign out_valid    = entry_valid[DEPTH-1];
  assign occupancy    = occ_q;
  assign stall_cycles = cnt_q;

  a_stall_monotone: assert property (@(posedge clk) disable iff (rst)
    !((in_stop == NoStop) && (out_stop == Stop)));

  a_params: assert property (@(posedge clk)
    (OUT_IDX == IN_IDX + 1) && (DEPTH >= 1) && (DEPTH <= PIPE_CHAIN_MAX_DEPTH));

endmodule

`default_nettype wire

// File: tb/tb_pipe_stage_chain.sv
// ---------------------------------------------------------------------------
// tb_pipe_stage_chain : directed + randomized checks against a queue model
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_pipe_stage_chain;

  localparam int W  = 152;
  localparam int D  = 2;
  localparam int W1 = 16;
  localparam int IB = 4;
  localparam int OB = 5;

  typedef struct packed {
    logic [W-1:0] b;
    logic         v;
  } ent_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // depth-2 stimulus shared by the 32-bit and 4-bit counter instances
  logic           rst, flush, in_valid;
  logic [5:0]     stall;
  logic [W-1:0]   in_bus;
  logic [W-1:0]   out_bus, out_bus_c4;
  logic           out_valid, out_valid_c4;
  logic [W*D-1:0] entry_bus, entry_bus_c4;
  logic [D-1:0]   entry_valid, entry_valid_c4;
  logic [1:0]     occupancy, occupancy_c4;
  logic [31:0]    stall_cycles;
  logic [3:0]     stall_cycles_c4;

  // depth-1 instance with its own stimulus
  logic          rst1, flush1, v1;
  logic [5:0]    stall1;
  logic [W1-1:0] in1, out1, ebus1;
  logic          ov1;
  logic [0:0]    ev1, occ1;
  logic [31:0]   cnt1;

  pipe_stage_chain #(.WIDTH(W), .DEPTH(D), .STALL_W(6), .IN_IDX(IB), .OUT_IDX(OB), .CNT_W(32)) dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush), .in_bus(in_bus), .in_valid(in_valid),
    .out_bus(out_bus), .out_valid(out_valid), .entry_bus(entry_bus), .entry_valid(entry_valid),
    .occupancy(occupancy), .stall_cycles(stall_cycles));

  pipe_stage_chain #(.WIDTH(W), .DEPTH(D), .STALL_W(6), .IN_IDX(IB), .OUT_IDX(OB), .CNT_W(4)) dut_c4 (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush), .in_bus(in_bus), .in_valid(in_valid),
    .out_bus(out_bus_c4), .out_valid(out_valid_c4), .entry_bus(entry_bus_c4),
    .entry_valid(entry_valid_c4), .occupancy(occupancy_c4), .stall_cycles(stall_cycles_c4));

  pipe_stage_chain #(.WIDTH(W1), .DEPTH(1), .STALL_W(6), .IN_IDX(IB), .OUT_IDX(OB), .CNT_W(32)) dut_d1 (
    .clk(clk), .rst(rst1), .stall(stall1), .flush(flush1), .in_bus(in1), .in_valid(v1),
    .out_bus(out1), .out_valid(ov1), .entry_bus(ebus1), .entry_valid(ev1),
    .occupancy(occ1), .stall_cycles(cnt1));

  int tests = 0;
  int fails = 0;

  // reference state: chain as a queue (index 0 = newest), legacy latch as a pair
  ent_t          mq[$];
  logic [31:0]   mcnt;
  logic [W1-1:0] l_bus;
  logic          l_valid;
  logic [31:0]   l_cnt;

  task automatic tick();
    ent_t e;
    @(posedge clk);
    if (rst) begin
      foreach (mq[i]) mq[i] = '0;
      mcnt = '0;
    end else begin
      if (stall[IB] && stall[OB]) mcnt = mcnt + 32'd1;
      if (flush) begin
        foreach (mq[i]) mq[i] = '0;
      end else if (!stall[IB] || !stall[OB]) begin
        e = '0;
        if (!stall[IB] && in_valid) begin
          e.b = in_bus;
          e.v = 1'b1;
        end
        mq.push_front(e);
        void'(mq.pop_back());
      end
    end
    if (rst1) begin
      l_bus = '0; l_valid = 1'b0; l_cnt = '0;
    end else begin
      if (stall1[IB] && stall1[OB]) l_cnt = l_cnt + 32'd1;
      if (flush1) begin
        l_bus = '0; l_valid = 1'b0;
      end else if (!stall1[IB]) begin
        l_valid = v1; l_bus = v1 ? in1 : '0;
      end else if (!stall1[OB]) begin
        l_bus = '0; l_valid = 1'b0;
      end
    end
    #1;
  endtask

  function automatic logic [5:0] rnd_stall();
    int k;
    k = $urandom_range(0, 6);
    return 6'((1 << k) - 1);
  endfunction

  function automatic logic [W-1:0] rnd_bus();
    return W'({$urandom, $urandom, $urandom, $urandom, $urandom});
  endfunction

  task automatic do_reset();
    rst = 1'b1; flush = 1'b0; stall = '0; in_valid = 1'b0; in_bus = '0;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; flush = 1'b0; stall = '0; in_bus = W'('h3); in_valid = 1'b1;
    rst1 = 1'b1; flush1 = 1'b0; stall1 = '0; in1 = W1'('h3); v1 = 1'b1;
    tick(); tick();
    tests++; if (out_bus !== '0) begin fails++; $display("FAIL reset_out_bus got %h want 0", out_bus); end
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    tests++; if (entry_bus !== '0) begin fails++; $display("FAIL reset_entry_bus got %h want 0", entry_bus); end
    tests++; if (entry_valid !== '0) begin fails++; $display("FAIL reset_entry_valid got %b want 0", entry_valid); end
    tests++; if (occupancy !== '0) begin fails++; $display("FAIL reset_occupancy got %0d want 0", occupancy); end
    tests++; if (stall_cycles !== '0) begin fails++; $display("FAIL reset_stall_cycles got %0d want 0", stall_cycles); end
    tests++; if (stall_cycles_c4 !== '0) begin fails++; $display("FAIL reset_stall_cycles_c4 got %0d want 0", stall_cycles_c4); end
    tests++; if ({out1, ov1, occ1} !== '0) begin fails++; $display("FAIL reset_d1 got %h want 0", {out1, ov1, occ1}); end
    rst = 1'b0; in_bus = W'('hA5); in_valid = 1'b1;
    tick();
    in_bus = '0; in_valid = 1'b0;
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL latency_early got out_valid=%b want 0", out_valid); end
    tick();
    tests++; if (out_bus !== W'('hA5)) begin fails++; $display("FAIL latency_bus got %h want a5", out_bus); end
    tests++; if (out_valid !== 1'b1) begin fails++; $display("FAIL latency_valid got %b want 1", out_valid); end
  endtask

  task automatic test_bubble();
    do_reset();
    in_bus = W'('hA5); in_valid = 1'b1;
    tick();
    stall = 6'b011111; in_bus = W'('h3C); in_valid = 1'b1;
    tick();
    tests++; if (entry_valid !== 2'b10) begin fails++; $display("FAIL bubble_valid got %b want 10", entry_valid); end
    tests++; if (entry_bus !== {W'('hA5), W'(0)}) begin fails++; $display("FAIL bubble_bus got %h want a5 in entry1 only", entry_bus); end
    tests++; if (stall_cycles !== 32'd0) begin fails++; $display("FAIL bubble_cnt got %0d want 0", stall_cycles); end
    stall = '0; in_bus = '0; in_valid = 1'b0;
    tick();
    tests++; if (out_bus !== '0 || out_valid !== 1'b0) begin fails++; $display("FAIL bubble_drain got %h/%b want 0/0", out_bus, out_valid); end
  endtask

  task automatic test_hold();
    do_reset();
    in_valid = 1'b1; in_bus = W'('h11);
    tick();
    in_bus = W'('h22);
    tick();
    stall = 6'b111111; in_bus = W'('hFF);
    repeat (3) tick();
    tests++; if (entry_bus !== {W'('h11), W'('h22)}) begin fails++; $display("FAIL hold_bus got %h want 11/22", entry_bus); end
    tests++; if (entry_valid !== 2'b11) begin fails++; $display("FAIL hold_valid got %b want 11", entry_valid); end
    tests++; if (occupancy !== 2'd2) begin fails++; $display("FAIL hold_occ got %0d want 2", occupancy); end
    tests++; if (stall_cycles !== 32'd3) begin fails++; $display("FAIL hold_cnt got %0d want 3", stall_cycles); end
  endtask

  task automatic test_flush();
    stall = '0; flush = 1'b1; in_bus = W'('h77); in_valid = 1'b1;
    tick();
    flush = 1'b0; in_valid = 1'b0; in_bus = '0;
    tests++; if (entry_valid !== '0) begin fails++; $display("FAIL flush_valid got %b want 0", entry_valid); end
    tests++; if (occupancy !== '0) begin fails++; $display("FAIL flush_occ got %0d want 0", occupancy); end
    tests++; if (entry_bus !== '0) begin fails++; $display("FAIL flush_bus got %h want 0", entry_bus); end
    tests++; if (stall_cycles !== 32'd3) begin fails++; $display("FAIL flush_cnt got %0d want 3", stall_cycles); end
    for (int i = 0; i < 2; i++) begin
      tick();
      tests++; if (out_bus !== '0) begin fails++; $display("FAIL flush_drop got %h want 0", out_bus); end
    end
    in_bus = W'('h55); in_valid = 1'b1;
    tick();
    stall = 6'b111111; flush = 1'b1;
    tick();
    tests++; if (entry_valid !== '0 || stall_cycles !== 32'd4) begin fails++; $display("FAIL flush_hold got %b/%0d want 0/4", entry_valid, stall_cycles); end
    stall = '0; flush = 1'b0; in_bus = W'('h66); in_valid = 1'b1;
    tick();
    in_valid = 1'b0; in_bus = '0;
    tests++; if (entry_valid !== 2'b01 || entry_bus !== {W'(0), W'('h66)}) begin fails++; $display("FAIL flush_resume got %b/%h want 01/66", entry_valid, entry_bus); end
    stall = 6'b111111;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0; stall = '0;
    tests++; if (entry_valid !== '0 || stall_cycles !== '0 || occupancy !== '0) begin fails++; $display("FAIL reset_mid_hold got %b/%0d/%0d want 0/0/0", entry_valid, stall_cycles, occupancy); end
  endtask

  task automatic test_counter_wrap();
    do_reset();
    stall = 6'b111111;
    repeat (17) tick();
    stall = '0;
    tests++; if (stall_cycles !== 32'd17) begin fails++; $display("FAIL wrap_cnt32 got %0d want 17", stall_cycles); end
    tests++; if (stall_cycles_c4 !== 4'd1) begin fails++; $display("FAIL wrap_cnt4 got %0d want 1", stall_cycles_c4); end
  endtask

  task automatic test_random();
    logic [1:0] exp_occ;
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      stall = rnd_stall();
      flush = ($urandom_range(0, 15) == 0);
      rst = ($urandom_range(0, 299) == 0);
      in_valid = $urandom_range(0, 3) != 0;
      in_bus = rnd_bus();
      tick();
      exp_occ = 2'(mq[0].v) + 2'(mq[1].v);
      tests++; if (out_bus !== mq[D-1].b || out_valid !== mq[D-1].v) begin fails++; $display("FAIL rand_out cyc %0d got %h/%b want %h/%b", n, out_bus, out_valid, mq[D-1].b, mq[D-1].v); end
      tests++; if (entry_bus !== {mq[1].b, mq[0].b}) begin fails++; $display("FAIL rand_entry_bus cyc %0d got %h want %h", n, entry_bus, {mq[1].b, mq[0].b}); end
      tests++; if (entry_valid !== {mq[1].v, mq[0].v}) begin fails++; $display("FAIL rand_entry_valid cyc %0d got %b want %b", n, entry_valid, {mq[1].v, mq[0].v}); end
      tests++; if (occupancy !== exp_occ) begin fails++; $display("FAIL rand_occ cyc %0d got %0d want %0d", n, occupancy, exp_occ); end
      tests++; if (stall_cycles !== mcnt) begin fails++; $display("FAIL rand_cnt cyc %0d got %0d want %0d", n, stall_cycles, mcnt); end
      tests++; if (stall_cycles_c4 !== mcnt[3:0]) begin fails++; $display("FAIL rand_cnt4 cyc %0d got %0d want %0d", n, stall_cycles_c4, mcnt[3:0]); end
    end
    rst = 1'b0; flush = 1'b0; stall = '0; in_valid = 1'b0;
  endtask

  task automatic test_depth1();
    rst1 = 1'b1; flush1 = 1'b0; stall1 = '0; v1 = 1'b0; in1 = '0;
    tick();
    rst1 = 1'b0;
    for (int n = 0; n < 10000; n++) begin
      stall1 = rnd_stall();
      flush1 = ($urandom_range(0, 19) == 0);
      v1 = $urandom_range(0, 3) != 0;
      in1 = W1'($urandom);
      tick();
      tests++; if (out1 !== l_bus || ebus1 !== l_bus) begin fails++; $display("FAIL d1_bus cyc %0d got %h/%h want %h", n, out1, ebus1, l_bus); end
      tests++; if (ov1 !== l_valid || ev1 !== l_valid || occ1 !== l_valid) begin fails++; $display("FAIL d1_valid cyc %0d got %b/%b/%b want %b", n, ov1, ev1, occ1, l_valid); end
      tests++; if (cnt1 !== l_cnt) begin fails++; $display("FAIL d1_cnt cyc %0d got %0d want %0d", n, cnt1, l_cnt); end
    end
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; stall = '0; in_bus = '0; in_valid = 1'b0;
    rst1 = 1'b1; flush1 = 1'b0; stall1 = '0; in1 = '0; v1 = 1'b0;
    mcnt = '0; l_bus = '0; l_valid = 1'b0; l_cnt = '0;
    repeat (D) mq.push_back('0);
    test_reset();
    test_bubble();
    test_hold();
    test_flush();
    test_counter_wrap();
    test_random();
    test_depth1();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/pipe_stage_chain.md
Name: pipe_stage_chain

Overview:
- Parametrised successor to the single-register EX→DC pipeline latch.
- Implements a DEPTH-entry shift chain for multi-cycle stages, e.g. a 2-cycle DC for a pipelined dcache.
- Driven by the global stall bus.
- Adds per-entry valid tracking, a flush port, an occupancy count and a stall-cycle perf counter.
- Sits between producer stage N and consumer stage N+1; forwarding logic taps every entry.

Parameters:
- WIDTH, 152, payload bits per entry (EX_TO_DC_WD in the current core).
- DEPTH, 2, number of chained entries (1..4); DEPTH=1 is the legacy single-latch behaviour.
- STALL_W, 6, width of stall bus (StallBus).
- IN_IDX, 4, stall bit gating entry into the chain.
- OUT_IDX, 5, stall bit of the consumer stage; must equal IN_IDX+1.
- CNT_W, 32, perf counter width.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  synchronous, active-high reset
- stall  in  STALL_W  global stall vector; Stop=1, NoStop=0
- flush  in  1  kill all in-flight entries (exception/redirect)
- in_bus  in  WIDTH  payload from producer stage
- in_valid  in  1  producer payload is a real instruction
- out_bus  out  WIDTH  payload of the last entry (entry DEPTH-1)
- out_valid  out  1  valid of the last entry
- entry_bus  out  WIDTH*DEPTH  all entries concatenated, entry 0 in LSBs, for forwarding
- entry_valid  out  DEPTH  per-entry valid
- occupancy  out  $clog2(DEPTH+1)  count of valid entries
- stall_cycles  out  CNT_W  cycles spent in HOLD since reset

Behaviour:
- One clock domain, clk. Reset is synchronous and active-high on rst.
- Reset: all entries and valids go to 0. out_bus=0, out_valid=0, entry_bus=0, entry_valid=0, occupancy=0, stall_cycles=0.
- Each cycle, exactly one action is taken, in this priority order:
  1. rst → reset as above.
  2. flush=1 → every entry payload and valid cleared to 0, regardless of stall. Counter is unaffected except that a HOLD-condition cycle still counts.
  3. stall[IN_IDX]==NoStop → SHIFT-IN: entry0←{in_bus,in_valid}; entry k←entry k-1.
  4. stall[IN_IDX]==Stop && stall[OUT_IDX]==NoStop → BUBBLE: entry0←all-zero payload with valid 0; entry k←entry k-1.
  5. Both Stop → HOLD: all entries unchanged; stall_cycles increments.
- An invalid entry always carries an all-zero payload, so downstream write-enable bits read 0 with no extra gating.
- stall[IN_IDX]==NoStop with stall[OUT_IDX]==Stop is illegal (the stall vector is monotone).
  - Behaviour in that case: SHIFT-IN.
  - A simulation-only assertion flags it.
- Latency: DEPTH cycles from in_bus sampled to out_bus, with no stalls.
- Outputs are registered: out_bus/out_valid come straight from the entry DEPTH-1 flops, with no comb path from inputs.
- occupancy is the popcount of entry_valid, registered; it updates in the same cycle as the entries.
- stall_cycles wraps modulo 2^CNT_W. It increments on HOLD and also when flush coincides with a both-Stop stall.
- Flush on the same edge as SHIFT-IN: flush wins and in_bus is dropped.
- Flush during HOLD: entries clear; the next non-stall cycle shifts normally.
- Reset asserted mid-HOLD clears everything on that edge; there are no pending states.
- DEPTH=1 must be bit-exact with the legacy latch: bubble, hold and load semantics are identical.

Decomposition:
- Shared defines (existing defines header): Stop/NoStop, StallBus, EX_TO_DC_WD, DC_TO_MEM_WD.
- Add a new constant PIPE_CHAIN_MAX_DEPTH=4.
- One natural sub-module: pipe_stage_entry, a single WIDTH+1 flop holding payload and valid.
  - Inputs: load/bubble/clear controls.
  - Instantiated DEPTH times via generate.
- Control decode, popcount and the counter live in the top module.

Test Plan:
- Reset: hold rst=1 for 2 cycles with in_bus=0x3 → all outputs 0. Release, send in_bus=0xA5 valid with DEPTH=2 and no stall → out_bus=0xA5 and out_valid=1 exactly 2 cycles later.
- Bubble: stall=6'b011111 for 1 cycle while entry0=0xA5 valid → entry0 becomes 0/invalid and entry1=0xA5. Next cycle with stall=0: out_bus=0 and out_valid=0.
- Hold: stall=6'b111111 for 3 cycles with entries {0x11,0x22} → entries unchanged, stall_cycles=3, occupancy=2.
- Flush: flush=1 together with stall=0 and in_bus=0x77 valid → all entry_valid=0, occupancy=0, and 0x77 never appears on out_bus.
- DEPTH=1 equivalence: random stall (monotone) and in_bus for 10k cycles, compared cycle-by-cycle against the legacy latch model → zero mismatches.
- Counter wrap (CNT_W=4): 17 HOLD cycles → stall_cycles=1.
